// File: rtl/mul_booth_arbiter.sv
// rtl/mul_booth_arbiter.sv - round-robin sequencer sharing one iterative Booth multiplier core
// Grants one requester at a time, loads the core through its reset, waits for end or timeout.
module mul_booth_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int REQ_NUM    = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [REQ_NUM-1:0]              i_req_valid,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]   i_req_num_x,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]   i_req_num_y,
  output logic [REQ_NUM-1:0]              o_req_ready,
  output logic                            o_rsp_valid,
  output logic [$clog2(REQ_NUM)-1:0]      o_rsp_id,
  output logic [2*DATA_WIDTH-1:0]         o_rsp_res,
  output logic                            o_rsp_cry,
  output logic                            o_rsp_err,
  input  logic                            i_rsp_ready,
  output logic                            o_mul_rst_n,
  output logic [DATA_WIDTH-1:0]           o_mul_num_x,
  output logic [DATA_WIDTH-1:0]           o_mul_num_y,
  input  logic                            i_mul_end,
  input  logic [2*DATA_WIDTH-1:0]         i_mul_res,
  input  logic                            i_mul_cry
);
  localparam int ID_W   = $clog2(REQ_NUM);
  localparam int WD_MAX = DATA_WIDTH / 2 + 3;
  localparam int WD_W   = $clog2(WD_MAX + 1);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(REQ_NUM - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(WD_MAX - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         last_q, last_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [DATA_WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic                    cry_q, cry_d;
  logic                    err_q, err_d;
  logic [WD_W-1:0]         wdog_q, wdog_d;
  logic [ID_W-1:0]         gnt_id;
  logic                    gnt_any;

  // Search starts just after the last served requester so every requester gets a turn.
  always_comb begin : rr_search
    int idx;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int i = 1; i <= REQ_NUM; i++) begin
      idx = (int'(last_q) + i) % REQ_NUM;
      if (!gnt_any && i_req_valid[idx]) begin
        gnt_id  = ID_W'(idx);
        gnt_any = 1'b1;
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (state_q == IDLE && gnt_any) o_req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    cry_d   = cry_q;
    err_d   = err_q;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          x_d     = i_req_num_x[gnt_id*DATA_WIDTH +: DATA_WIDTH];
          y_d     = i_req_num_y[gnt_id*DATA_WIDTH +: DATA_WIDTH];
          id_d    = gnt_id;
          last_d  = gnt_id;
          state_d = LOAD;
        end
      end
      LOAD: begin
        wdog_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        // The core's end flag survives its reset, so the first RUN cycle cannot trust it.
        if (wdog_q != '0 && i_mul_end) begin
          res_d   = i_mul_res;
          cry_d   = i_mul_cry;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wdog_q == WD_LAST) begin
          res_d   = '0;
          cry_d   = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      cry_q   <= 1'b0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      cry_q   <= cry_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_id    = id_q;
  assign o_rsp_res   = res_q;
  assign o_rsp_cry   = cry_q;
  assign o_rsp_err   = err_q;
  assign o_mul_rst_n = (state_q == RUN);
  assign o_mul_num_x = x_q;
  assign o_mul_num_y = y_q;

endmodule

// File: tb/tb_mul_booth_arbiter.sv
// tb/tb_mul_booth_arbiter.sv - scoreboard bench for mul_booth_arbiter with a behavioural core
module tb_mul_booth_arbiter;
  localparam int DW   = 8;
  localparam int RN   = 4;
  localparam int IW   = 2;
  localparam int TOUT = DW / 2 + 3;
  localparam int QD   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n     = 1'b0;
  logic              rsp_ready = 1'b1;
  logic              kill_end  = 1'b0;
  logic [RN-1:0]     req_valid = '0;
  logic [RN*DW-1:0]  req_x     = '0;
  logic [RN*DW-1:0]  req_y     = '0;
  logic [RN-1:0]     req_ready;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [2*DW-1:0]   rsp_res;
  logic              rsp_cry, rsp_err;
  logic              mul_rst_n;
  logic [DW-1:0]     mul_x, mul_y;
  logic              mul_end = 1'b0;
  logic [2*DW-1:0]   mul_res = '0;
  logic              mul_cry = 1'b0;

  mul_booth_arbiter #(.DATA_WIDTH(DW), .REQ_NUM(RN)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_num_x(req_x), .i_req_num_y(req_y),
    .o_req_ready(req_ready),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_res(rsp_res),
    .o_rsp_cry(rsp_cry), .o_rsp_err(rsp_err), .i_rsp_ready(rsp_ready),
    .o_mul_rst_n(mul_rst_n), .o_mul_num_x(mul_x), .o_mul_num_y(mul_y),
    .i_mul_end(mul_end), .i_mul_res(mul_res), .i_mul_cry(mul_cry)
  );

  function automatic logic [2*DW-1:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  // Core model: latches operands while held in reset; end flag is not cleared by reset.
  logic [DW-1:0] cx = '0, cy = '0;
  int            cyc = 0;
  always @(posedge clk) begin
    if (!mul_rst_n) begin
      cx  <= mul_x;
      cy  <= mul_y;
      cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (!kill_end && (cyc + 2 >= ((cy == '0) ? 2 : DW / 2 + 1))) begin
        mul_end <= 1'b1;
        mul_res <= prod(cx, cy);
        mul_cry <= ^prod(cx, cy);
      end else begin
        mul_end <= 1'b0;
      end
    end
  end

  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  logic [DW-1:0] opx[RN][QD];
  logic [DW-1:0] opy[RN][QD];
  int head[RN] = '{default: 0};
  int tail[RN] = '{default: 0};

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < RN; k++) begin
      req_valid[k]         = (head[k] != tail[k]);
      req_x[k*DW +: DW]    = (head[k] != tail[k]) ? opx[k][head[k]] : '0;
      req_y[k*DW +: DW]    = (head[k] != tail[k]) ? opy[k][head[k]] : '0;
    end
  end

  typedef struct packed {
    logic [IW-1:0]   id;
    logic [2*DW-1:0] res;
    logic            cry;
    logic            err;
  } exp_t;
  exp_t sb[$];
  int   gnt_log[$];
  logic prev_valid = 1'b0;
  int   hs_cnt = 0, last_lat = 0, ready_cycles = 0, run_cycles = 0, rsp_count = 0;
  logic [2*DW-1:0] last_res = '0;
  logic [IW-1:0]   last_id = '0;
  logic            last_err = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      prev_valid = 1'b0;
    end else begin
      hs_cnt++;
      check("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
      if (req_ready != '0) ready_cycles++;
      if (mul_rst_n) run_cycles++;
      for (int k = 0; k < RN; k++) begin
        if (req_ready[k] && req_valid[k]) begin
          e.id  = IW'(k);
          e.res = kill_end ? '0 : prod(opx[k][head[k]], opy[k][head[k]]);
          e.cry = kill_end ? 1'b0 : ^prod(opx[k][head[k]], opy[k][head[k]]);
          e.err = kill_end;
          sb.push_back(e);
          gnt_log.push_back(k);
          head[k]++;
          hs_cnt = 0;
        end
      end
      if (rsp_valid && !prev_valid) last_lat = hs_cnt;
      prev_valid = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        last_res = rsp_res;
        last_id  = rsp_id;
        last_err = rsp_err;
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_res", 64'(rsp_res), 64'(e.res));
          check("rsp_cry", 64'(rsp_cry), 64'(e.cry));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end
    end
  end

  task automatic push_op(input int k, input logic [DW-1:0] x, input logic [DW-1:0] y);
    opx[k][tail[k]] = x;
    opy[k][tail[k]] = y;
    tail[k]++;
  endtask

  function automatic bit all_done();
    for (int k = 0; k < RN; k++) if (head[k] != tail[k]) return 1'b0;
    return (sb.size() == 0) && !rsp_valid;
  endfunction

  task automatic drain(input string tag, input int budget);
    int t = 0;
    @(negedge clk);
    while (!all_done() && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) check({tag, "_drain_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int rb, runb, gb, rc, t;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_res", 64'(rsp_res), 64'd0);
    check("rst_rsp_cry_err", 64'({rsp_cry, rsp_err}), 64'd0);
    check("rst_mul_rst_n", 64'(mul_rst_n), 64'd0);
    check("rst_mul_xy", 64'({mul_x, mul_y}), 64'd0);
    rst_n = 1'b1;

    rb = ready_cycles; runb = run_cycles;
    push_op(0, 8'd3, 8'd5);
    drain("t1", 100);
    check("t1_res", 64'(last_res), 64'h000F);
    check("t1_id", 64'(last_id), 64'd0);
    check("t1_err", 64'(last_err), 64'd0);
    check("t1_ready_cycles", 64'(ready_cycles - rb), 64'd1);
    check("t1_run_cycles", 64'(run_cycles - runb), 64'd5);
    check("t1_latency", 64'(last_lat), 64'd7);

    push_op(2, 8'hFD, 8'h07);
    drain("neg", 100);
    check("neg_res", 64'(last_res), 64'hFFEB);
    check("neg_id", 64'(last_id), 64'd2);
    push_op(2, 8'h80, 8'h80);
    drain("min", 100);
    check("min_res", 64'(last_res), 64'h4000);

    push_op(1, 8'd7, 8'd9);
    push_op(1, 8'd9, 8'd0);
    drain("stale", 200);
    check("stale_res", 64'(last_res), 64'd0);
    check("stale_latency", 64'(last_lat), 64'd4);

    @(negedge clk) rst_n = 1'b0;
    for (int k = 0; k < RN; k++) begin
      push_op(k, 8'(k * 17 + 2), 8'(k * 5 + 3));
      push_op(k, 8'(8'hF0 - k * 9), 8'(k + 6));
    end
    repeat (2) @(negedge clk);
    gb = gnt_log.size();
    rst_n = 1'b1;
    drain("rot", 400);
    check("rot_count", 64'(gnt_log.size() - gb), 64'd8);
    for (int i = 0; i < 8; i++)
      if (gb + i < gnt_log.size()) check("rot_order", 64'(gnt_log[gb + i]), 64'(i % RN));

    rsp_ready = 1'b0;
    push_op(3, 8'h25, 8'hF3);
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    check("bp_wait", 64'(rsp_valid), 64'd1);
    push_op(1, 8'd11, 8'd12);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_res", 64'(rsp_res), 64'(prod(8'h25, 8'hF3)));
      check("bp_id", 64'(rsp_id), 64'd3);
      check("bp_no_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_next_grant", 64'(req_ready), 64'b0010);
    drain("bp", 200);

    kill_end = 1'b1;
    push_op(0, 8'h11, 8'h22);
    drain("tout", 200);
    check("tout_err", 64'(last_err), 64'd1);
    check("tout_res", 64'(last_res), 64'd0);
    check("tout_latency", 64'(last_lat), 64'(TOUT + 2));
    kill_end = 1'b0;

    push_op(1, 8'd5, 8'd6);
    t = 0;
    while (!mul_rst_n && t < 50) begin @(negedge clk); t++; end
    check("mid_run_seen", 64'(mul_rst_n), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_mul_rst_n", 64'(mul_rst_n), 64'd0);
    check("mid_mul_xy", 64'({mul_x, mul_y}), 64'd0);
    check("mid_req_ready", 64'(req_ready), 64'd0);
    check("mid_rsp_res_id", 64'({rsp_res, rsp_id}), 64'd0);
    rc = rsp_count;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("mid_no_rsp", 64'(rsp_count - rc), 64'd0);
    gb = gnt_log.size();
    push_op(3, 8'd2, 8'd4);
    push_op(0, 8'd6, 8'hFE);
    drain("post", 200);
    check("post_count", 64'(gnt_log.size() - gb), 64'd2);
    if (gnt_log.size() >= gb + 2) begin
      check("post_first", 64'(gnt_log[gb]), 64'd0);
      check("post_second", 64'(gnt_log[gb + 1]), 64'd3);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
